// File: rtl/mod_reduct_solinas2_pkg.sv
// Elaboration-time helpers for the solinas2 modular reducer.
// Derives the modulus exponent k, the fold count, per-stage widths,
// slice offsets into the flattened data pipeline and the total latency.
package mod_reduct_solinas2_pkg;

  localparam int unsigned MAX_MOD_W = 128;
  localparam int unsigned MAX_FOLD  = 16;
  localparam int unsigned FW_W      = 16;
  localparam int unsigned FI_W      = $clog2(MAX_FOLD + 1);
  localparam int unsigned DIFF_W    = MAX_MOD_W + 1;

  // Entry 0 is the operand width, entry i the width after fold i.
  typedef logic [MAX_FOLD:0][FW_W-1:0] fold_w_t;

  // Returns k such that mod_m = 2^mod_w - 2^k + 1, or 0 when mod_m has no such form.
  function automatic int unsigned get_int_pow(input int unsigned mod_w,
                                              input logic [MAX_MOD_W-1:0] mod_m);
    logic [DIFF_W-1:0] diff;
    int unsigned       k;
    k    = 0;
    diff = (DIFF_W'(1) << mod_w) + DIFF_W'(1) - DIFF_W'(mod_m);
    for (int unsigned i = 1; i + 2 <= mod_w; i++) begin
      if (diff == (DIFF_W'(1) << i)) k = i;
    end
    return k;
  endfunction

  // Width of y = (hi << k) - hi + lo for an input of width wi.
  function automatic int unsigned get_fold_out_w(input int unsigned mod_w, k, wi);
    int unsigned grown;
    grown = wi - mod_w + k;
    return ((grown > mod_w) ? grown : mod_w) + 1;
  endfunction

  function automatic int unsigned get_fold_nb(input int unsigned mod_w, k, op_w);
    int unsigned w;
    int unsigned n;
    w = op_w;
    n = 0;
    while ((w > mod_w + 1) && (n < MAX_FOLD)) begin
      w = get_fold_out_w(mod_w, k, w);
      n++;
    end
    return n;
  endfunction

  function automatic fold_w_t get_fold_w(input int unsigned mod_w, k, op_w);
    fold_w_t     fw;
    int unsigned w;
    fw    = '0;
    w     = op_w;
    fw[0] = FW_W'(w);
    for (int unsigned i = 1; i <= MAX_FOLD; i++) begin
      if (w > mod_w + 1) w = get_fold_out_w(mod_w, k, w);
      fw[FI_W'(i)] = FW_W'(w);
    end
    return fw;
  endfunction

  // Bit offset of stage idx inside the flattened data vector.
  function automatic int unsigned get_fold_off(input fold_w_t fw, input int unsigned idx);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < idx; i++) begin
      off += 32'(fw[FI_W'(i)]);
    end
    return off;
  endfunction

  function automatic int unsigned get_lat(input int unsigned in_pipe, nb_fold);
    return in_pipe + nb_fold + 1;
  endfunction

endpackage

// File: rtl/common_lib_delay_side.sv
// One-cycle delay of an avail qualifier plus sideband.
// Ports: clk, s_rst_n (synchronous, active-low), in_avail/in_side -> out_avail/out_side.
// RST_SIDE[0] resets sideband to 0, RST_SIDE[1] to 1, neither leaves it unreset.
module common_lib_delay_side #(
  parameter int unsigned SIDE_W   = 1,
  parameter logic [1:0]  RST_SIDE = 2'b00
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              in_avail,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_avail,
  output logic [SIDE_W-1:0] out_side
);

  always_ff @(posedge clk) begin
    if (!s_rst_n) out_avail <= 1'b0;
    else          out_avail <= in_avail;
  end

  generate
    if (RST_SIDE[0]) begin : g_side_rst0
      always_ff @(posedge clk) begin
        if (!s_rst_n) out_side <= '0;
        else          out_side <= in_side;
      end
    end else if (RST_SIDE[1]) begin : g_side_rst1
      always_ff @(posedge clk) begin
        if (!s_rst_n) out_side <= '1;
        else          out_side <= in_side;
      end
    end else begin : g_side_norst
      always_ff @(posedge clk) out_side <= in_side;
    end
  endgenerate

endmodule

// File: rtl/mod_reduct_solinas2_fold.sv
// One registered fold step using 2^MOD_W == 2^K - 1 (mod p).
// Ports: clk; x (IN_W) input; y (OUT_W) = (x_hi << K) - x_hi + x_lo, registered.
module mod_reduct_solinas2_fold
  import mod_reduct_solinas2_pkg::*;
#(
  parameter int unsigned MOD_W = 64,
  parameter int unsigned K     = 32,
  parameter int unsigned IN_W  = 128,
  parameter int unsigned OUT_W = 97
) (
  input  logic             clk,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  localparam int unsigned HI_W = IN_W - MOD_W;

  logic [HI_W-1:0]  hi;
  logic [MOD_W-1:0] lo;
  logic [OUT_W-1:0] hi_ext;
  logic [OUT_W-1:0] lo_ext;
  logic [OUT_W-1:0] y_c;

  assign hi     = x[IN_W-1:MOD_W];
  assign lo     = x[MOD_W-1:0];
  assign hi_ext = OUT_W'(hi);
  assign lo_ext = OUT_W'(lo);

  // (hi << K) >= hi, so the subtraction never wraps.
  assign y_c = (hi_ext << K) - hi_ext + lo_ext;

  always_ff @(posedge clk) y <= y_c;

endmodule

// File: rtl/mod_reduct_solinas2.sv
// Pipelined reduction of a wide operand modulo p = 2^MOD_W - 2^k + 1.
// Ports: clk, s_rst (sync, active-high); a/in_avail/in_side operand input;
// z/out_avail/out_side canonical residue in [0, p) after LAT cycles.
module mod_reduct_solinas2
  import mod_reduct_solinas2_pkg::*;
#(
  parameter int unsigned      MOD_W    = 64,
  parameter logic [MOD_W-1:0] MOD_M    = MOD_W'(64'hFFFF_FFFF_0000_0001),
  parameter int unsigned      OP_W     = 2 * MOD_W,
  parameter bit               IN_PIPE  = 1'b1,
  parameter int unsigned      SIDE_W   = 0,
  parameter logic [1:0]       RST_SIDE = 2'b00
) (
  input  logic                                 clk,
  input  logic                                 s_rst,
  input  logic [OP_W-1:0]                      a,
  input  logic                                 in_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
  output logic [MOD_W-1:0]                     z,
  output logic                                 out_avail,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

  localparam int unsigned K       = get_int_pow(MOD_W, MAX_MOD_W'(MOD_M));
  localparam int unsigned NB_FOLD = get_fold_nb(MOD_W, K, OP_W);
  localparam fold_w_t     FOLD_W  = get_fold_w(MOD_W, K, OP_W);
  localparam int unsigned LAT     = get_lat(32'(IN_PIPE), NB_FOLD);
  localparam int unsigned SW      = (SIDE_W > 0) ? SIDE_W : 1;
  localparam int unsigned DAT_W   = get_fold_off(FOLD_W, NB_FOLD + 1);
  localparam int unsigned C_OFF   = get_fold_off(FOLD_W, NB_FOLD);
  localparam int unsigned C_W     = 32'(FOLD_W[FI_W'(NB_FOLD)]);
  localparam int unsigned XC_W    = MOD_W + 2;

  // Reject parameter sets the datapath cannot handle.
  generate
    if ((MOD_W < 3) || (MOD_W > MAX_MOD_W)) begin : g_bad_w
      $fatal(1, "mod_reduct_solinas2: MOD_W=%0d out of range", MOD_W);
    end
    if (K == 0) begin : g_bad_mod
      $fatal(1, "mod_reduct_solinas2: MOD_M=%0h is not 2^MOD_W - 2^k + 1", MOD_M);
    end
    if (OP_W < MOD_W + 1) begin : g_bad_op
      $fatal(1, "mod_reduct_solinas2: OP_W=%0d must be at least MOD_W+1", OP_W);
    end
    if (NB_FOLD >= MAX_FOLD) begin : g_bad_fold
      $fatal(1, "mod_reduct_solinas2: too many fold stages");
    end
  endgenerate

  // All stage data, flattened; stage i lives at get_fold_off(FOLD_W, i).
  logic [DAT_W-1:0] dat;

  // Optional input register.
  generate
    if (IN_PIPE) begin : g_in_pipe
      logic [OP_W-1:0] a_q;
      always_ff @(posedge clk) a_q <= a;
      assign dat[OP_W-1:0] = a_q;
    end else begin : g_in_comb
      assign dat[OP_W-1:0] = a;
    end
  endgenerate

  // Fold chain: each step shrinks the width until it fits in MOD_W+1 bits.
  generate
    for (genvar i = 0; i < NB_FOLD; i++) begin : g_fold
      localparam int unsigned IW   = 32'(FOLD_W[FI_W'(i)]);
      localparam int unsigned OW   = 32'(FOLD_W[FI_W'(i + 1)]);
      localparam int unsigned IOFF = get_fold_off(FOLD_W, i);
      localparam int unsigned OOFF = get_fold_off(FOLD_W, i + 1);
      logic [OW-1:0] y;
      mod_reduct_solinas2_fold #(
        .MOD_W(MOD_W),
        .K    (K),
        .IN_W (IW),
        .OUT_W(OW)
      ) u_fold (
        .clk(clk),
        .x  (dat[IOFF +: IW]),
        .y  (y)
      );
      assign dat[OOFF +: OW] = y;
    end
  endgenerate

  // Correction: x < 2^(MOD_W+1) < 3p, so one of x, x-p, x-2p is canonical.
  localparam logic [XC_W-1:0] P1 = XC_W'(MOD_M);
  localparam logic [XC_W-1:0] P2 = XC_W'(MOD_M) << 1;

  logic [XC_W-1:0] xc;
  logic [XC_W-1:0] d1;
  logic [XC_W-1:0] d2;

  assign xc = XC_W'(dat[C_OFF +: C_W]);
  assign d1 = xc - P1;
  assign d2 = xc - P2;

  always_ff @(posedge clk) begin
    if (!d2[XC_W-1])      z <= MOD_W'(d2);
    else if (!d1[XC_W-1]) z <= MOD_W'(d1);
    else                  z <= MOD_W'(xc);
  end

  // Avail/sideband pipeline, one delay per data stage.
  logic [LAT:0]         av;
  logic [LAT:0][SW-1:0] sd;

  assign av[0] = in_avail;
  assign sd[0] = in_side;

  generate
    for (genvar j = 0; j < LAT; j++) begin : g_dly
      common_lib_delay_side #(
        .SIDE_W  (SW),
        .RST_SIDE(RST_SIDE)
      ) u_dly (
        .clk      (clk),
        .s_rst_n  (~s_rst),
        .in_avail (av[j]),
        .in_side  (sd[j]),
        .out_avail(av[j+1]),
        .out_side (sd[j+1])
      );
    end
  endgenerate

  assign out_avail = av[LAT];
  assign out_side  = sd[LAT];

endmodule

// File: tb/tb_mod_reduct_solinas2.sv
// Self-checking bench for mod_reduct_solinas2: default Goldilocks instance
// plus a MOD_W=32, k=20 instance, checked against a % p reference.
module tb_mod_reduct_solinas2;

  localparam logic [127:0] P   = 128'hFFFF_FFFF_0000_0001;
  localparam logic [63:0]  P32 = 64'h0000_0000_FFF0_0001;
  localparam int           LAT = 5;

  logic         clk = 1'b0;
  logic         s_rst = 1'b1;
  logic [127:0] a = '0;
  logic         in_avail = 1'b0;
  logic [15:0]  in_side = '0;
  logic [63:0]  z;
  logic         out_avail;
  logic [15:0]  out_side;

  logic [63:0]  a32 = '0;
  logic         in_avail32 = 1'b0;
  logic         in_side32 = 1'b0;
  logic [31:0]  z32;
  logic         out_avail32;
  logic         out_side32;

  mod_reduct_solinas2 #(
    .MOD_W(64), .MOD_M(64'hFFFF_FFFF_0000_0001), .OP_W(128),
    .IN_PIPE(1'b1), .SIDE_W(16), .RST_SIDE(2'b01)
  ) dut (
    .clk(clk), .s_rst(s_rst), .a(a), .in_avail(in_avail), .in_side(in_side),
    .z(z), .out_avail(out_avail), .out_side(out_side)
  );

  mod_reduct_solinas2 #(
    .MOD_W(32), .MOD_M(32'hFFF0_0001), .OP_W(64),
    .IN_PIPE(1'b1), .SIDE_W(0), .RST_SIDE(2'b00)
  ) dut32 (
    .clk(clk), .s_rst(s_rst), .a(a32), .in_avail(in_avail32), .in_side(in_side32),
    .z(z32), .out_avail(out_avail32), .out_side(out_side32)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [127:0] a; logic [15:0] side; } op_t;
  typedef struct { int cyc; logic [63:0] z; logic [15:0] side; } obs_t;
  typedef struct { int cyc; logic [31:0] z; logic side; } ob32_t;

  op_t   drv[$];
  obs_t  obs[$];
  ob32_t obs32[$];
  bit    av_log[int];
  bit    in_log[int];

  int checks = 0;
  int errors = 0;

  // Output recorder: logs every cycle's out_avail and every valid result.
  always @(negedge clk) begin
    av_log[cyc] = (out_avail === 1'b1);
    if (out_avail === 1'b1) obs.push_back('{cyc, z, out_side});
    if (out_avail32 === 1'b1) obs32.push_back('{cyc, z32, out_side32});
  end

  function automatic logic [63:0] ref_mod(input logic [127:0] x);
    return 64'(x % P);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic [127:0] va, input bit v, input logic [15:0] side, input bit rst);
    @(negedge clk);
    a        = va;
    in_avail = v;
    in_side  = side;
    s_rst    = rst;
    in_log[cyc] = v;
    if (v) drv.push_back('{cyc, va, side});
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_avail !== 1'b0) begin
      errors++; $display("FAIL reset_avail: got %b, required 0", out_avail);
    end
    checks++;
    if (out_side !== 16'h0000) begin
      errors++; $display("FAIL reset_side: got %h, required 0000", out_side);
    end
    checks++;
    if (out_avail32 !== 1'b0) begin
      errors++; $display("FAIL reset_avail32: got %b, required 0", out_avail32);
    end
    idle(8);
    checks++;
    if (obs.size() != 0) begin
      errors++; $display("FAIL reset_idle: got %0d outputs, required 0", obs.size());
    end
    drv.delete(); obs.delete();
  endtask

  task automatic test_canonical();
    logic [63:0] ez [3];
    ez = '{64'd0, 64'd0, 64'd5};
    drv.delete(); obs.delete();
    drive('0, 1'b1, 16'd1, 1'b0);
    drive(P, 1'b1, 16'd2, 1'b0);
    drive(P + 128'd5, 1'b1, 16'd3, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs.size()) begin
        errors++; $display("FAIL canonical[%0d]: no output, required z=%h", i, ez[i]);
      end else if (obs[i].z !== ez[i] || obs[i].cyc !== drv[i].cyc + LAT || obs[i].side !== drv[i].side) begin
        errors++;
        $display("FAIL canonical[%0d]: got z=%h cyc=%0d side=%0d, required z=%h cyc=%0d side=%0d",
                 i, obs[i].z, obs[i].cyc, obs[i].side, ez[i], drv[i].cyc + LAT, drv[i].side);
      end
    end
    checks++;
    if (obs.size() != 3) begin
      errors++; $display("FAIL canonical_count: got %0d, required 3", obs.size());
    end
  endtask

  task automatic test_boundary();
    logic [127:0] va [3];
    logic [63:0]  ez [3];
    logic [127:0] pm1;
    pm1   = P - 128'd1;
    va[0] = 128'd1 << 64;
    va[1] = '1;
    va[2] = pm1 * pm1;
    ez    = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0000, 64'd1};
    drv.delete(); obs.delete();
    for (int i = 0; i < 3; i++) drive(va[i], 1'b1, 16'(i + 10), 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs.size()) begin
        errors++; $display("FAIL boundary[%0d]: no output, required z=%h", i, ez[i]);
      end else if (obs[i].z !== ez[i] || obs[i].cyc !== drv[i].cyc + LAT) begin
        errors++;
        $display("FAIL boundary[%0d]: got z=%h cyc=%0d, required z=%h cyc=%0d",
                 i, obs[i].z, obs[i].cyc, ez[i], drv[i].cyc + LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10000;
    logic [127:0] x;
    drv.delete(); obs.delete();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 15))
        0:       x = '1;
        1:       x = P * 128'($urandom);
        2:       x = P - 128'd1;
        3:       x = 128'($urandom) << 64;
        default: x = rand128();
      endcase
      drive(x, 1'b1, 16'(i), 1'b0);
    end
    idle(10);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (i >= obs.size()) begin
        errors++; $display("FAIL b2b[%0d]: no output, required z=%h", i, ref_mod(drv[i].a));
      end else if (obs[i].z !== ref_mod(drv[i].a) || obs[i].side !== drv[i].side ||
                   obs[i].cyc !== drv[i].cyc + LAT) begin
        errors++;
        $display("FAIL b2b[%0d]: got z=%h side=%0d cyc=%0d, required z=%h side=%0d cyc=%0d",
                 i, obs[i].z, obs[i].side, obs[i].cyc, ref_mod(drv[i].a), drv[i].side, drv[i].cyc + LAT);
      end
    end
    checks++;
    if (obs.size() != N) begin
      errors++; $display("FAIL b2b_count: got %0d, required %0d", obs.size(), N);
    end
  endtask

  task automatic test_random_avail();
    int cl[$];
    drv.delete(); obs.delete();
    for (int i = 0; i < 400; i++) begin
      drive(rand128(), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      cl.push_back(cyc);
    end
    idle(10);
    foreach (cl[i]) begin
      checks++;
      if (av_log[cl[i] + LAT] !== in_log[cl[i]]) begin
        errors++;
        $display("FAIL avail_pattern[%0d]: got %b, required %b", i, av_log[cl[i] + LAT], in_log[cl[i]]);
      end
    end
    foreach (drv[i]) begin
      checks++;
      if (i >= obs.size()) begin
        errors++; $display("FAIL rand_avail[%0d]: no output, required z=%h", i, ref_mod(drv[i].a));
      end else if (obs[i].z !== ref_mod(drv[i].a) || obs[i].cyc !== drv[i].cyc + LAT ||
                   obs[i].side !== drv[i].side) begin
        errors++;
        $display("FAIL rand_avail[%0d]: got z=%h cyc=%0d, required z=%h cyc=%0d",
                 i, obs[i].z, obs[i].cyc, ref_mod(drv[i].a), drv[i].cyc + LAT);
      end
    end
    checks++;
    if (obs.size() != drv.size()) begin
      errors++; $display("FAIL rand_avail_count: got %0d, required %0d", obs.size(), drv.size());
    end
  endtask

  // Six warm-up operands keep the pipeline busy, then 8 more with s_rst
  // high while the fourth of them is presented. An operand presented at
  // cycle c is lost exactly when the reset cycle r satisfies c <= r <= c+4.
  task automatic test_reset_midstream();
    op_t keep[$];
    int  r;
    drv.delete(); obs.delete();
    r = -1;
    for (int i = 0; i < 14; i++) begin
      drive(rand128(), 1'b1, 16'(16'h100 + i), i == 9);
      if (i == 9) r = cyc;
    end
    idle(10);
    foreach (drv[i]) if (drv[i].cyc < r - 4 || drv[i].cyc > r) keep.push_back(drv[i]);
    checks++;
    if (av_log[r + 1] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_avail: got %b at cycle after reset, required 0", av_log[r + 1]);
    end
    foreach (keep[i]) begin
      checks++;
      if (i >= obs.size()) begin
        errors++; $display("FAIL rst_mid[%0d]: no output, required side=%h", i, keep[i].side);
      end else if (obs[i].side !== keep[i].side || obs[i].z !== ref_mod(keep[i].a) ||
                   obs[i].cyc !== keep[i].cyc + LAT) begin
        errors++;
        $display("FAIL rst_mid[%0d]: got side=%h z=%h cyc=%0d, required side=%h z=%h cyc=%0d",
                 i, obs[i].side, obs[i].z, obs[i].cyc, keep[i].side, ref_mod(keep[i].a), keep[i].cyc + LAT);
      end
    end
    checks++;
    if (obs.size() != keep.size()) begin
      errors++; $display("FAIL rst_mid_count: got %0d, required %0d", obs.size(), keep.size());
    end
  endtask

  task automatic test_sweep32();
    ob32_t exp32[$];
    logic [63:0] x;
    obs32.delete();
    for (int i = 0; i < 300; i++) begin
      case (i)
        0:       x = '0;
        1:       x = P32;
        2:       x = '1;
        3:       x = (P32 - 64'd1) * (P32 - 64'd1);
        4:       x = 64'd1 << 32;
        default: x = {$urandom, $urandom};
      endcase
      @(negedge clk);
      a32        = x;
      in_avail32 = 1'b1;
      in_side32  = i[0];
      exp32.push_back('{cyc, 32'(x % P32), i[0]});
    end
    @(negedge clk);
    in_avail32 = 1'b0;
    idle(10);
    foreach (exp32[i]) begin
      checks++;
      if (i >= obs32.size()) begin
        errors++; $display("FAIL sweep32[%0d]: no output, required z=%h", i, exp32[i].z);
      end else if (obs32[i].z !== exp32[i].z || obs32[i].side !== exp32[i].side ||
                   obs32[i].cyc !== exp32[i].cyc + LAT) begin
        errors++;
        $display("FAIL sweep32[%0d]: got z=%h side=%b cyc=%0d, required z=%h side=%b cyc=%0d",
                 i, obs32[i].z, obs32[i].side, obs32[i].cyc, exp32[i].z, exp32[i].side, exp32[i].cyc + LAT);
      end
    end
    checks++;
    if (obs32.size() != exp32.size()) begin
      errors++; $display("FAIL sweep32_count: got %0d, required %0d", obs32.size(), exp32.size());
    end
  endtask

  initial begin
    test_reset();
    test_canonical();
    test_boundary();
    test_back_to_back();
    test_random_avail();
    test_reset_midstream();
    test_sweep32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
